// File: rtl/vx_tcu_drl_vld_mask_seq_pkg.sv
// Shared TCU format IDs, granule lookup and beat record for the DRL valid-mask sequencer.
package vx_tcu_drl_vld_mask_seq_pkg;

`ifndef TCU_BF16_ENABLE
`define TCU_BF16_ENABLE 1
`endif
`ifndef TCU_TF32_ENABLE
`define TCU_TF32_ENABLE 1
`endif
`ifndef TCU_FP8_ENABLE
`define TCU_FP8_ENABLE 1
`endif
`ifndef TCU_INT_ENABLE
`define TCU_INT_ENABLE 1
`endif

  localparam int TCU_MAX_INPUTS = 16;

  localparam bit TCU_BF16_EN = `TCU_BF16_ENABLE;
  localparam bit TCU_TF32_EN = `TCU_TF32_ENABLE;
  localparam bit TCU_FP8_EN  = `TCU_FP8_ENABLE;
  localparam bit TCU_INT_EN  = `TCU_INT_ENABLE;

  localparam logic [3:0] TCU_FP32_ID = 4'd0;
  localparam logic [3:0] TCU_FP16_ID = 4'd1;
  localparam logic [3:0] TCU_BF16_ID = 4'd2;
  localparam logic [3:0] TCU_TF32_ID = 4'd3;
  localparam logic [3:0] TCU_FP8_ID  = 4'd4;
  localparam logic [3:0] TCU_BF8_ID  = 4'd5;
  localparam logic [3:0] TCU_I32_ID  = 4'd8;
  localparam logic [3:0] TCU_I8_ID   = 4'd9;
  localparam logic [3:0] TCU_U8_ID   = 4'd10;
  localparam logic [3:0] TCU_I4_ID   = 4'd11;
  localparam logic [3:0] TCU_U4_ID   = 4'd12;

  // Granules per element; 0 marks a format this build cannot carry.
  function automatic logic [3:0] tcu_fmt_gran(input logic [3:0] fmt);
    logic [3:0] g;
    g = 4'd0;
    case (fmt)
      TCU_FP16_ID:                           g = 4'd4;
      TCU_BF16_ID:                           g = TCU_BF16_EN ? 4'd4 : 4'd0;
      TCU_TF32_ID:                           g = TCU_TF32_EN ? 4'd8 : 4'd0;
      TCU_FP8_ID, TCU_BF8_ID:                g = TCU_FP8_EN  ? 4'd2 : 4'd0;
      TCU_I8_ID, TCU_U8_ID:                  g = TCU_INT_EN  ? 4'd2 : 4'd0;
      TCU_I4_ID, TCU_U4_ID:                  g = TCU_INT_EN  ? 4'd1 : 4'd0;
      default:                               g = 4'd0;
    endcase
    return g;
  endfunction

  typedef struct packed {
    logic [TCU_MAX_INPUTS-1:0] mask;
    logic [3:0]                fmt;
    logic                      last;
    logic                      err;
  } tcu_vld_beat_t;

  typedef enum logic {
    ST_IDLE,
    ST_RUN
  } vld_seq_state_e;

endpackage

// File: rtl/vx_tcu_drl_vld_mask_seq_therm.sv
// Count-to-thermometer: bit j of mask is set iff j < count.
module vx_tcu_drl_therm_mask #(
  parameter int GRAN = 16
) (
  input  logic [$clog2(GRAN+1)-1:0] count,
  output logic [GRAN-1:0]           mask
);

  always_comb begin
    mask = '0;
    for (int unsigned j = 0; j < GRAN; j++) begin
      mask[j] = (j < 32'(count));
    end
  end

endmodule

// File: rtl/vx_tcu_drl_vld_mask_seq.sv
// Transmit side of the TCU DRL valid-mask interface: one K request in, a stream of
// per-beat granule valid masks out.
module vx_tcu_drl_vld_mask_seq
  import vx_tcu_drl_vld_mask_seq_pkg::*;
#(
  parameter int N     = 2,
  parameter int TCK   = 2 * N,
  parameter int GRAN  = TCU_MAX_INPUTS,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [3:0]       req_fmt,
  input  logic [CNT_W-1:0] req_count,
  output logic             beat_valid,
  input  logic             beat_ready,
  output logic [GRAN-1:0]  beat_vld_mask,
  output logic [3:0]       beat_fmt,
  output logic             beat_last,
  output logic             beat_err
);

  localparam int CW = $clog2(GRAN + 1);

  if (GRAN != TCU_MAX_INPUTS || GRAN < 8 || (GRAN % 8) != 0 || TCK < 2) begin : g_bad_cfg
    $error("vx_tcu_drl_vld_mask_seq: unsupported GRAN/TCK configuration");
  end

  function automatic logic [CNT_W-1:0] elems_per_beat(input logic [3:0] g);
    logic [CNT_W-1:0] e;
    case (g)
      4'd8:    e = CNT_W'(GRAN) >> 3;
      4'd4:    e = CNT_W'(GRAN) >> 2;
      4'd2:    e = CNT_W'(GRAN) >> 1;
      4'd1:    e = CNT_W'(GRAN);
      default: e = '0;
    endcase
    return e;
  endfunction

  function automatic logic [CNT_W-1:0] take(input logic [CNT_W-1:0] rem, input logic [3:0] g);
    logic [CNT_W-1:0] e;
    e = elems_per_beat(g);
    return (rem < e) ? rem : e;
  endfunction

  vld_seq_state_e   state_q;
  tcu_vld_beat_t    beat_q, beat_d;
  logic             beat_valid_q;
  logic [CNT_W-1:0] rem_q, rem_d, e_d, n_d;
  logic [3:0]       gran_q, gran_d;
  logic [CW-1:0]    therm_cnt;
  logic [GRAN-1:0]  therm_mask;
  logic             idle;

  // One datapath forms both the first beat (from the request) and each following beat
  // (from the residual count), so the beat register loads identically in either state.
  always_comb begin
    idle      = (state_q == ST_IDLE);
    gran_d    = idle ? tcu_fmt_gran(req_fmt) : gran_q;
    rem_d     = idle ? req_count : (rem_q - take(rem_q, gran_q));
    e_d       = elems_per_beat(gran_d);
    n_d       = take(rem_d, gran_d);
    therm_cnt = CW'(n_d) * CW'(gran_d);

    beat_d      = '0;
    beat_d.mask = therm_mask;
    beat_d.fmt  = idle ? req_fmt : beat_q.fmt;
    beat_d.err  = (gran_d == 4'd0);
    beat_d.last = (gran_d == 4'd0) || (rem_d <= e_d);
  end

  vx_tcu_drl_therm_mask #(
    .GRAN (GRAN)
  ) u_therm (
    .count (therm_cnt),
    .mask  (therm_mask)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      beat_valid_q <= 1'b0;
      beat_q       <= '0;
      rem_q        <= '0;
      gran_q       <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            state_q      <= ST_RUN;
            beat_valid_q <= 1'b1;
            beat_q       <= beat_d;
            rem_q        <= rem_d;
            gran_q       <= gran_d;
          end
        end
        ST_RUN: begin
          if (beat_ready) begin
            if (beat_q.last) begin
              state_q      <= ST_IDLE;
              beat_valid_q <= 1'b0;
            end else begin
              beat_q <= beat_d;
              rem_q  <= rem_d;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign req_ready     = (state_q == ST_IDLE);
  assign beat_valid    = beat_valid_q;
  assign beat_vld_mask = beat_q.mask;
  assign beat_fmt      = beat_q.fmt;
  assign beat_last     = beat_q.last;
  assign beat_err      = beat_q.err;

endmodule

// File: tb/tb_vx_tcu_drl_vld_mask_seq.sv
// Self-checking bench for vx_tcu_drl_vld_mask_seq (GRAN=16) against a request-level model.
module tb_vx_tcu_drl_vld_mask_seq;
  import vx_tcu_drl_vld_mask_seq_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_fmt;
  logic [15:0] req_count;
  logic        beat_valid;
  logic        beat_ready;
  logic [15:0] beat_vld_mask;
  logic [3:0]  beat_fmt;
  logic        beat_last;
  logic        beat_err;

  typedef struct {
    logic [15:0] mask;
    logic [3:0]  fmt;
    logic        last;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  vx_tcu_drl_vld_mask_seq #(
    .N     (2),
    .GRAN  (16),
    .CNT_W (16)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_fmt       (req_fmt),
    .req_count     (req_count),
    .beat_valid    (beat_valid),
    .beat_ready    (beat_ready),
    .beat_vld_mask (beat_vld_mask),
    .beat_fmt      (beat_fmt),
    .beat_last     (beat_last),
    .beat_err      (beat_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Request-level model: split count elements into beats of GRAN/G elements each.
  task automatic push_model(input logic [3:0] fmt, input int count);
    int g, e, rem, n, bits;
    logic [31:0] m;
    exp_t x;
    case (fmt)
      TCU_TF32_ID:                                  g = 8;
      TCU_FP16_ID, TCU_BF16_ID:                     g = 4;
      TCU_FP8_ID, TCU_BF8_ID, TCU_I8_ID, TCU_U8_ID: g = 2;
      TCU_I4_ID, TCU_U4_ID:                         g = 1;
      default:                                      g = 0;
    endcase
    if (g == 0) begin
      x.mask = 16'h0000; x.fmt = fmt; x.last = 1'b1; x.err = 1'b1;
      exp_q.push_back(x);
    end else begin
      e   = 16 / g;
      rem = count;
      do begin
        n    = (rem < e) ? rem : e;
        bits = n * g;
        m    = (32'd1 << bits) - 32'd1;
        x.mask = m[15:0]; x.fmt = fmt; x.last = (rem <= e); x.err = 1'b0;
        exp_q.push_back(x);
        rem -= n;
      end while (!x.last);
    end
  endtask

  // Compare process: every consumed beat against the model, plus stall stability.
  logic        hold_pend = 1'b0;
  logic [21:0] held;
  always @(negedge clk) begin
    exp_t e;
    if (reset_n === 1'b1) begin
      if (hold_pend) begin
        chk("stall_valid", {31'd0, beat_valid}, 32'd1);
        chk("stall_hold", {10'd0, beat_vld_mask, beat_fmt, beat_last, beat_err}, {10'd0, held});
      end
      if (beat_valid && beat_ready) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_beat: got mask 0x%0h expected no beat", beat_vld_mask);
        end else begin
          e = exp_q.pop_front();
          chk("beat_mask", {16'd0, beat_vld_mask}, {16'd0, e.mask});
          chk("beat_fmt",  {28'd0, beat_fmt},      {28'd0, e.fmt});
          chk("beat_last", {31'd0, beat_last},     {31'd0, e.last});
          chk("beat_err",  {31'd0, beat_err},      {31'd0, e.err});
        end
      end
      hold_pend = beat_valid && !beat_ready;
      held      = {beat_vld_mask, beat_fmt, beat_last, beat_err};
    end else begin
      hold_pend = 1'b0;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input logic [3:0] fmt, input logic [15:0] count);
    int t;
    t = 0;
    while (!req_ready && t < 50) begin
      cyc();
      t++;
    end
    if (!req_ready) begin
      checks++; errors++;
      $display("FAIL req_ready_timeout: got 0 expected 1");
    end
    req_valid = 1'b1;
    req_fmt   = fmt;
    req_count = count;
    cyc();
    req_valid = 1'b0;
    req_fmt   = 4'hF;
    req_count = 16'hFFFF;
  endtask

  task automatic wait_idle(input string nm);
    int t;
    t = 0;
    while ((exp_q.size() != 0 || beat_valid) && t < 60) begin
      cyc();
      t++;
    end
    chk({nm, "_drained"}, exp_q.size(), 0);
    chk({nm, "_idle_ready"}, {31'd0, req_ready}, 32'd1);
  endtask

  initial begin
    reset_n    = 1'b0;
    req_valid  = 1'b0;
    req_fmt    = 4'd0;
    req_count  = 16'd0;
    beat_ready = 1'b1;
    cyc();
    cyc();
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_beat_valid", {31'd0, beat_valid}, 32'd0);
    chk("rst_state", {10'd0, beat_vld_mask, beat_fmt, beat_last, beat_err}, 32'd0);
    reset_n = 1'b1;
    cyc();

    // FP16 x10: three back-to-back beats.
    push_model(TCU_FP16_ID, 10);
    chk("pin_fp16_n", exp_q.size(), 3);
    chk("pin_fp16_b0", {exp_q[0].mask, 15'd0, exp_q[0].last}, {16'hFFFF, 16'd0});
    chk("pin_fp16_b1", {exp_q[1].mask, 15'd0, exp_q[1].last}, {16'hFFFF, 16'd0});
    chk("pin_fp16_b2", {exp_q[2].mask, 15'd0, exp_q[2].last}, {16'h00FF, 16'd1});
    accept(TCU_FP16_ID, 16'd10);
    chk("fp16_busy", {31'd0, req_ready}, 32'd0);
    cyc();
    cyc();
    chk("fp16_b2b_mid", exp_q.size(), 1);
    cyc();
    chk("fp16_b2b_end", exp_q.size(), 0);
    chk("fp16_bubble", {31'd0, beat_valid}, 32'd0);
    chk("fp16_ready_again", {31'd0, req_ready}, 32'd1);

    push_model(TCU_FP8_ID, 3);
    chk("pin_fp8", {exp_q[0].mask, 15'd0, exp_q[0].last}, {16'h003F, 16'd1});
    accept(TCU_FP8_ID, 16'd3);
    wait_idle("fp8");

    push_model(TCU_I4_ID, 20);
    chk("pin_i4", {exp_q[0].mask, exp_q[1].mask}, {16'hFFFF, 16'h000F});
    accept(TCU_I4_ID, 16'd20);
    wait_idle("i4");

    push_model(TCU_TF32_ID, 3);
    chk("pin_tf32", {exp_q[0].mask, exp_q[1].mask}, {16'hFFFF, 16'h00FF});
    accept(TCU_TF32_ID, 16'd3);
    wait_idle("tf32");

    push_model(TCU_BF16_ID, 0);
    chk("pin_zero", {exp_q[0].mask, 14'd0, exp_q[0].last, exp_q[0].err}, {16'h0000, 16'd2});
    accept(TCU_BF16_ID, 16'd0);
    wait_idle("zero");

    // Unsupported format held under backpressure.
    push_model(4'hF, 7);
    chk("pin_unsup", {exp_q[0].mask, 14'd0, exp_q[0].last, exp_q[0].err}, {16'h0000, 16'd3});
    beat_ready = 1'b0;
    accept(4'hF, 16'd7);
    chk("unsup_valid", {31'd0, beat_valid}, 32'd1);
    chk("unsup_busy0", {31'd0, req_ready}, 32'd0);
    cyc();
    cyc();
    chk("unsup_busy2", {31'd0, req_ready}, 32'd0);
    beat_ready = 1'b1;
    cyc();
    chk("unsup_ready", {31'd0, req_ready}, 32'd1);
    chk("unsup_done", {31'd0, beat_valid}, 32'd0);
    wait_idle("unsup");

    // FP16 x10 with beat 2 stalled three cycles.
    push_model(TCU_FP16_ID, 10);
    accept(TCU_FP16_ID, 16'd10);
    cyc();
    beat_ready = 1'b0;
    repeat (3) cyc();
    beat_ready = 1'b1;
    wait_idle("stall");

    // Reset after beat 1 abandons the request.
    push_model(TCU_FP16_ID, 10);
    accept(TCU_FP16_ID, 16'd10);
    cyc();
    reset_n = 1'b0;
    cyc();
    chk("midrst_valid", {31'd0, beat_valid}, 32'd0);
    chk("midrst_ready", {31'd0, req_ready}, 32'd1);
    exp_q.delete();
    reset_n = 1'b1;
    repeat (3) cyc();
    chk("midrst_quiet", {31'd0, beat_valid}, 32'd0);

    push_model(TCU_I8_ID, 9);
    chk("pin_i8", {exp_q[0].mask, exp_q[1].mask}, {16'hFFFF, 16'h0003});
    accept(TCU_I8_ID, 16'd9);
    wait_idle("post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
